cache_mem_arbiter: RTL and testbench
====================================

Name: cache_mem_arbiter

Overview:
- Shares the single physical-memory line port between the instruction cache and the data cache.
- Arbitrates line-fill and write-back requests. Each transaction moves one full 256-bit line (the same burst format that cache word selection consumes).
- Sits between both cache controllers and physical memory.
- Grants round-robin on contention, holds the grant until memory responds, and counts contention events for performance analysis.

Parameters:
ADDR_WIDTH, 16, byte address width of requests and the memory port
LINE_WIDTH, 256, line/burst width in bits (16 words of 16 bits)
CNT_WIDTH, 16, width of the saturating contention counter

Ports:
clk  in  1  system clock; all state updates on rising edge
reset_n  in  1  synchronous active-low reset
i_read  in  1  I-cache line read request; held until i_resp
i_addr  in  ADDR_WIDTH  I-cache line address
i_rdata  out  LINE_WIDTH  line data to I-cache
i_resp  out  1  I-cache transaction complete (1-cycle pulse)
d_read  in  1  D-cache line read request; held until d_resp
d_write  in  1  D-cache line write-back request; held until d_resp
d_addr  in  ADDR_WIDTH  D-cache line address
d_wdata  in  LINE_WIDTH  D-cache write-back line
d_rdata  out  LINE_WIDTH  line data to D-cache
d_resp  out  1  D-cache transaction complete (1-cycle pulse)
pmem_read  out  1  memory read strobe
pmem_write  out  1  memory write strobe
pmem_addr  out  ADDR_WIDTH  memory address
pmem_wdata  out  LINE_WIDTH  memory write line
pmem_rdata  in  LINE_WIDTH  memory read line
pmem_resp  in  1  memory transaction complete
contention_cnt  out  CNT_WIDTH  cycles in which both caches were requesting while IDLE

Behaviour:
- State register values: IDLE, SERVE_I, SERVE_D.
  - last_served register: I or D.
  - contention_cnt register.
- Reset (reset_n=0 at a clock edge, synchronous):
  - state=IDLE, last_served=I, contention_cnt=0.
  - pmem_read, pmem_write, i_resp and d_resp are all 0 while in IDLE.
  - Reset mid-transaction abandons the transaction: no resp is issued, and strobes drop the cycle after the reset edge.
- IDLE:
  - No pmem strobes; pmem_addr=0; pmem_wdata=0.
  - Request-pending definitions: i_req=i_read; d_req=d_read|d_write.
  - Only i_req pending -> SERVE_I.
  - Only d_req pending -> SERVE_D.
  - Both pending -> grant the side not equal to last_served; contention_cnt increments (saturates at all-ones, no wrap).
  - Grant decision is registered; strobes appear one cycle after the request is first seen.
- SERVE_I:
  - pmem_read=1, pmem_addr=i_addr, pmem_write=0.
  - i_resp = pmem_resp (combinational, same cycle).
  - On pmem_resp: last_served<=I, state<=IDLE.
- SERVE_D:
  - pmem_addr=d_addr.
  - pmem_write=d_write, pmem_wdata=d_wdata, pmem_read=d_read & ~d_write (write has priority if both are asserted).
  - d_resp = pmem_resp.
  - On pmem_resp: last_served<=D, state<=IDLE.
- Read data fan-out: i_rdata and d_rdata are both driven from pmem_rdata continuously. Only the resp of the granted side qualifies the data.
- A non-owner's resp is always 0. pmem_resp while in IDLE is ignored.
- Requester drops its request mid-service:
  - Grant is still held until pmem_resp, since memory cannot abort.
  - Strobes follow the owner's live inputs, so in SERVE_D a dropped d_write/d_read deasserts the strobes. Memory must tolerate this; the arbiter does not force completion.
- Minimum one IDLE cycle between back-to-back transactions (turnaround). The requester sees resp and deasserts before the next arbitration.
- New requests arriving during a SERVE state wait; they are not lost and are evaluated in the next IDLE cycle.
- Latency per transaction = 1 (grant) + memory latency. Back-to-back same-requester throughput = memory latency + 2 cycles.

Test Plan:
- Reset then lone I request: i_read=1, i_addr=16'h1240, memory responds 3 cycles after strobe -> pmem_read high from cycle 1, pmem_addr=16'h1240, i_resp single pulse coincident with pmem_resp, i_rdata=pmem_rdata, d_resp=0, contention_cnt=0.
- Lone D write-back: d_write=1, d_addr=16'h8000, d_wdata=pattern A5..A5 -> pmem_write=1, pmem_read=0, pmem_wdata matches, d_resp pulse; with d_read and d_write both high, only pmem_write is asserted.
- Simultaneous requests after reset -> first grant to D (last_served=I), contention_cnt=1. I is served next without a second increment if D has dropped. Repeated dual contention alternates D,I,D,I.
- Request arrives mid-service: during SERVE_D, i_read rises -> no pmem change until d_resp; one IDLE cycle; then SERVE_I with pmem_addr=i_addr.
- Reset asserted in SERVE_I with pmem_resp still pending -> next cycle state IDLE, pmem_read=0, no i_resp, contention_cnt=0, last_served=I.
- Counter saturation: force 2^CNT_WIDTH+5 contention events (CNT_WIDTH=4 in bench) -> contention_cnt holds 4'hF, no wrap.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - I/D cache arbiter for the shared physical-memory line port
module cache_mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 256,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_addr,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp,
  output logic [CNT_WIDTH-1:0]  contention_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t state;
  logic   last_served_d;
  logic   i_req;
  logic   d_req;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      last_served_d  <= 1'b0;
      contention_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req && d_req) begin
            // Contention: hand the port to whoever did not go last.
            state <= last_served_d ? SERVE_I : SERVE_D;
            if (contention_cnt != {CNT_WIDTH{1'b1}})
              contention_cnt <= contention_cnt + CNT_WIDTH'(1);
          end else if (i_req) begin
            state <= SERVE_I;
          end else if (d_req) begin
            state <= SERVE_D;
          end
        end
        SERVE_I: begin
          if (pmem_resp) begin
            last_served_d <= 1'b0;
            state         <= IDLE;
          end
        end
        SERVE_D: begin
          if (pmem_resp) begin
            last_served_d <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes track the owner's live request lines; a reset cycle never completes a transaction.
  always_comb begin
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    pmem_addr  = '0;
    pmem_wdata = '0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    case (state)
      SERVE_I: begin
        pmem_read = 1'b1;
        pmem_addr = i_addr;
        i_resp    = pmem_resp & reset_n;
      end
      SERVE_D: begin
        pmem_write = d_write;
        pmem_read  = d_read & ~d_write;
        pmem_addr  = d_addr;
        pmem_wdata = d_wdata;
        d_resp     = pmem_resp & reset_n;
      end
      default: ;
    endcase
  end

  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - self-checking bench for cache_mem_arbiter
module tb_cache_mem_arbiter;

  localparam int AW = 16;
  localparam int LW = 256;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          i_read = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read = 1'b0;
  logic          d_write = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [LW-1:0] d_wdata = '0;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_addr;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata = '0;
  logic          pmem_resp = 1'b0;
  logic [CW-1:0] contention_cnt;

  cache_mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .contention_cnt(contention_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: who owns the port, who went last, how many contention events.
  int          m_owner = 0;  // 0 none, 1 I-cache, 2 D-cache
  bit          m_last_d = 1'b0;
  int          m_cnt = 0;
  logic          e_rd, e_wr, e_ir, e_dr;
  logic [AW-1:0] e_ad;
  logic [LW-1:0] e_wd;
  logic          last_i_resp = 1'b0;
  logic          last_d_resp = 1'b0;

  always @(negedge clk) begin
    e_rd = 1'b0; e_wr = 1'b0; e_ir = 1'b0; e_dr = 1'b0; e_ad = '0; e_wd = '0;
    if (m_owner == 1) begin
      e_rd = 1'b1;
      e_ad = i_addr;
      e_ir = pmem_resp && reset_n;
    end else if (m_owner == 2) begin
      e_wr = d_write;
      e_rd = d_read && !d_write;
      e_ad = d_addr;
      e_wd = d_wdata;
      e_dr = pmem_resp && reset_n;
    end
    chk("pmem_read", pmem_read, e_rd);
    chk("pmem_write", pmem_write, e_wr);
    chk("pmem_addr", pmem_addr, e_ad);
    if (m_owner != 1) chk("pmem_wdata", pmem_wdata, e_wd);
    chk("i_resp", i_resp, e_ir);
    chk("d_resp", d_resp, e_dr);
    chk("i_rdata", i_rdata, pmem_rdata);
    chk("d_rdata", d_rdata, pmem_rdata);
    chk("contention_cnt", contention_cnt, LW'(m_cnt));
    last_i_resp = i_resp;
    last_d_resp = d_resp;
    if (!reset_n) begin
      m_owner = 0; m_last_d = 1'b0; m_cnt = 0;
    end else if (m_owner == 0) begin
      if (i_read && (d_read || d_write)) begin
        m_owner = m_last_d ? 1 : 2;
        if (m_cnt < (1 << CW) - 1) m_cnt++;
      end else if (i_read) m_owner = 1;
      else if (d_read || d_write) m_owner = 2;
    end else if (pmem_resp) begin
      m_last_d = (m_owner == 2);
      m_owner = 0;
    end
  end

  // Memory: answers a strobe after a fixed or random latency, optionally with stray resps.
  int  mem_lat = 3;
  bit  mem_rand = 1'b0;
  bit  mem_stray = 1'b0;
  bit  mbusy = 1'b0;
  int  mcnt = 0;
  bit  s_seen, r_seen, rst_seen;

  always begin
    @(negedge clk);
    s_seen = pmem_read | pmem_write;
    r_seen = pmem_resp;
    rst_seen = !reset_n;
    @(posedge clk);
    #1;
    for (int k = 0; k < LW / 32; k++) pmem_rdata[k*32 +: 32] = $urandom;
    pmem_resp = 1'b0;
    if (rst_seen) mbusy = 1'b0;
    else begin
      if (!mbusy && s_seen && !r_seen) begin
        mbusy = 1'b1;
        mcnt = mem_rand ? int'($urandom_range(1, 4)) : mem_lat;
      end
      if (mbusy) begin
        mcnt--;
        if (mcnt == 0) begin
          pmem_resp = 1'b1;
          mbusy = 1'b0;
        end
      end else if (mem_stray && $urandom_range(0, 7) == 0) pmem_resp = 1'b1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_any(output int who, output int n);
    who = 0;
    n = 0;
    while (who == 0 && n < 50) begin
      @(negedge clk);
      n++;
      if (i_resp === 1'b1) who = 1;
      else if (d_resp === 1'b1) who = 2;
    end
    chk("resp_arrived", LW'(who != 0), 1);
  endtask

  int who, n;

  initial begin
    repeat (2) cyc();
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_cnt", contention_cnt, 0);
    chk("rst_read", pmem_read, 0);
    chk("rst_write", pmem_write, 0);

    // Lone I-cache fill, memory latency 3.
    cyc(); i_read = 1'b1; i_addr = 16'h1240;
    @(negedge clk); chk("t1_idle_no_strobe", pmem_read, 0);
    cyc(); @(negedge clk);
    chk("t1_read", pmem_read, 1);
    chk("t1_addr", pmem_addr, 16'h1240);
    wait_any(who, n);
    chk("t1_side", LW'(who), 1);
    chk("t1_latency", LW'(n), 3);
    chk("t1_d_resp", d_resp, 0);
    chk("t1_cnt", contention_cnt, 0);
    cyc(); i_read = 1'b0;

    // D write-back with read also raised: write wins.
    d_read = 1'b1; d_write = 1'b1; d_addr = 16'h8000; d_wdata = {32{8'hA5}};
    cyc(); @(negedge clk);
    chk("t2_write", pmem_write, 1);
    chk("t2_read", pmem_read, 0);
    chk("t2_addr", pmem_addr, 16'h8000);
    chk("t2_wdata", pmem_wdata, {32{8'hA5}});
    wait_any(who, n);
    chk("t2_side", LW'(who), 2);
    cyc(); d_read = 1'b0; d_write = 1'b0;

    // D drops its write mid-service: strobe falls, grant held until resp.
    cyc(); d_write = 1'b1; d_addr = 16'h9000;
    cyc(); @(negedge clk); chk("t3_write", pmem_write, 1);
    cyc(); d_write = 1'b0;
    @(negedge clk);
    chk("t3_write_dropped", pmem_write, 0);
    chk("t3_addr_held", pmem_addr, 16'h9000);
    wait_any(who, n);
    chk("t3_side", LW'(who), 2);

    // I request arrives while D is being served.
    cyc(); d_read = 1'b1; d_addr = 16'h3300;
    cyc(); i_read = 1'b1; i_addr = 16'h4440;
    @(negedge clk); chk("t4_addr_d", pmem_addr, 16'h3300);
    wait_any(who, n);
    chk("t4_side_d", LW'(who), 2);
    cyc(); d_read = 1'b0;
    @(negedge clk); chk("t4_turnaround", pmem_read, 0);
    cyc(); @(negedge clk);
    chk("t4_addr_i", pmem_addr, 16'h4440);
    chk("t4_read_i", pmem_read, 1);
    wait_any(who, n);
    chk("t4_side_i", LW'(who), 1);
    chk("t4_cnt", contention_cnt, 0);
    cyc(); i_read = 1'b0;

    // Reset while I transaction is pending.
    cyc(); i_read = 1'b1; i_addr = 16'h5550;
    cyc(); @(negedge clk); chk("t5_read", pmem_read, 1);
    cyc(); reset_n = 1'b0;
    cyc(); reset_n = 1'b1; i_read = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("t5_no_read", pmem_read, 0);
      chk("t5_no_resp", i_resp, 0);
    end
    chk("t5_cnt", contention_cnt, 0);

    // Simultaneous requests after reset: D first, then I without another count.
    cyc(); i_read = 1'b1; i_addr = 16'h2000; d_read = 1'b1; d_addr = 16'h3000;
    cyc(); @(negedge clk);
    chk("t6_first_d", pmem_addr, 16'h3000);
    chk("t6_cnt1", contention_cnt, 1);
    wait_any(who, n);
    chk("t6_side_d", LW'(who), 2);
    cyc(); d_read = 1'b0;
    wait_any(who, n);
    chk("t6_side_i", LW'(who), 1);
    chk("t6_cnt_still1", contention_cnt, 1);
    cyc(); i_read = 1'b0;

    // Sustained dual contention: alternation and counter saturation.
    reset_n = 1'b0;
    cyc(); reset_n = 1'b1; i_read = 1'b1; d_read = 1'b1;
    for (int k = 0; k < (1 << CW) + 5; k++) begin
      wait_any(who, n);
      chk("t7_alternate", LW'(who), (k % 2 == 0) ? 2 : 1);
    end
    chk("t7_saturated", contention_cnt, 4'hF);
    #1 chk("t7_model_saturated", LW'(m_cnt), 15);
    cyc(); i_read = 1'b0; d_read = 1'b0;
    cyc();

    // Randomized traffic against the model.
    mem_rand = 1'b1;
    mem_stray = 1'b1;
    repeat (3000) begin
      cyc();
      reset_n = ($urandom_range(0, 199) != 0);
      if (i_read) begin
        if (last_i_resp || $urandom_range(0, 15) == 0) i_read = 1'b0;
      end else if ($urandom_range(0, 1) == 1) begin
        i_read = 1'b1;
        i_addr = 16'($urandom);
      end
      if (d_read || d_write) begin
        if (last_d_resp || $urandom_range(0, 15) == 0) begin
          d_read = 1'b0; d_write = 1'b0;
        end
      end else if ($urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 2))
          0: begin d_read = 1'b1; d_write = 1'b0; end
          1: begin d_read = 1'b0; d_write = 1'b1; end
          default: begin d_read = 1'b1; d_write = 1'b1; end
        endcase
        d_addr = 16'($urandom);
        for (int k = 0; k < LW / 32; k++) d_wdata[k*32 +: 32] = $urandom;
      end
    end
    cyc(); reset_n = 1'b1; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    repeat (10) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
